// File: rtl/z80_pkg.sv
// Shared types for the Z80 memory responder: FSM state encoding and wait-counter width.
package z80_pkg;

    localparam int WAIT_CTR_W = 4;

    typedef logic [WAIT_CTR_W-1:0] wait_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_DRIVE = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_WR_WAIT  = 3'd5,
        ST_WR_HOLD  = 3'd6
    } mem_resp_state_t;

endpackage

// File: rtl/z80_wait_ctr.sv
// Wait-state countdown: loads a cycle count, decrements to zero and stops there.
module z80_wait_ctr
    import z80_pkg::*;
(
    input  logic      clk,
    input  logic      rst_L,
    input  logic      load,
    input  logic      clear,
    input  wait_cnt_t load_val,
    output wait_cnt_t count,
    output logic      zero
);

    wait_cnt_t count_reg;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/z80_mem_responder.sv
// Z80 bus slave that turns MREQ/RD/WR cycles into single-cycle RAM strobes,
// stretching the CPU with WAIT_L and driving registered read data back.
module z80_mem_responder
    import z80_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        MREQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        RFSH_L,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        WAIT_L,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        bus_err
);

    localparam wait_cnt_t WS_LOAD = wait_cnt_t'(WAIT_STATES);

    mem_resp_state_t state_reg, state_next;
    logic            armed_reg;
    logic            rd_cap_reg;
    logic            wait_l_reg, wait_l_next;
    logic            data_oe_reg;
    logic [7:0]      data_out_reg;
    logic [15:0]     mem_addr_reg;
    logic [7:0]      mem_wdata_reg;
    logic            mem_re_reg, mem_we_reg, bus_err_reg;

    logic      accept_rd, accept_wr, flag_err;
    logic      cpu_rd, cpu_wr, cpu_err, strobes_idle, rd_live, wr_live;
    logic      ctr_load, ctr_clear, ctr_zero, ctr_last, in_countdown;
    wait_cnt_t ctr_count;

    assign cpu_rd       = !MREQ_L && !RD_L &&  WR_L && RFSH_L;
    assign cpu_wr       = !MREQ_L && !WR_L &&  RD_L && RFSH_L;
    assign cpu_err      = !MREQ_L && !RD_L && !WR_L && RFSH_L;
    assign strobes_idle = MREQ_L || (RD_L && WR_L);
    assign rd_live      = !MREQ_L && !RD_L;
    assign wr_live      = !MREQ_L && !WR_L;

    // Count still shows the pre-edge value, so <=1 means "zero after this edge".
    assign ctr_last     = ctr_zero || (ctr_count == wait_cnt_t'(1));
    assign in_countdown = (state_reg == ST_RD_ISSUE) || (state_reg == ST_RD_WAIT) ||
                          (state_reg == ST_WR_ISSUE) || (state_reg == ST_WR_WAIT);

    always_comb begin
        state_next = state_reg;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        flag_err   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (armed_reg) begin
                    if (cpu_rd) begin
                        state_next = ST_RD_ISSUE;
                        accept_rd  = 1'b1;
                    end else if (cpu_wr) begin
                        state_next = ST_WR_ISSUE;
                        accept_wr  = 1'b1;
                    end else if (cpu_err) begin
                        flag_err   = 1'b1;
                    end
                end
            end
            ST_RD_ISSUE: state_next = rd_live ? ST_RD_WAIT : ST_IDLE;
            ST_RD_WAIT: begin
                if (!rd_live)      state_next = ST_IDLE;
                else if (ctr_last) state_next = ST_RD_DRIVE;
            end
            ST_RD_DRIVE: if (!rd_live) state_next = ST_IDLE;
            ST_WR_ISSUE, ST_WR_WAIT: begin
                if (!wr_live)      state_next = ST_IDLE;
                else if (ctr_last) state_next = ST_WR_HOLD;
                else               state_next = ST_WR_WAIT;
            end
            ST_WR_HOLD: if (!wr_live) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_l_next = 1'b1;
        if (accept_rd || accept_wr) begin
            wait_l_next = (WS_LOAD == '0);
        end else if (in_countdown && state_next != ST_IDLE) begin
            wait_l_next = ctr_last;
        end
    end

    assign ctr_load  = accept_rd || accept_wr;
    assign ctr_clear = (state_reg != ST_IDLE) && (state_next == ST_IDLE);

    z80_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst_L    (rst_L),
        .load     (ctr_load),
        .clear    (ctr_clear),
        .load_val (WS_LOAD),
        .count    (ctr_count),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_reg     <= ST_IDLE;
            armed_reg     <= 1'b0;
            rd_cap_reg    <= 1'b0;
            wait_l_reg    <= 1'b1;
            data_oe_reg   <= 1'b0;
            data_out_reg  <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wait_l_reg  <= wait_l_next;
            data_oe_reg <= (state_next == ST_RD_DRIVE);
            mem_re_reg  <= accept_rd;
            mem_we_reg  <= accept_wr;
            bus_err_reg <= flag_err;
            // RAM data is valid only in the cycle after mem_re: the first RD_WAIT edge.
            rd_cap_reg  <= (state_reg == ST_RD_ISSUE);
            if (state_reg == ST_RD_WAIT && rd_cap_reg) begin
                data_out_reg <= mem_rdata;
            end
            if (accept_rd || accept_wr) begin
                mem_addr_reg <= addr;
            end
            if (accept_wr) begin
                mem_wdata_reg <= data_in;
            end
            // Re-arm only after an idle cycle with strobes released, so held strobes never re-trigger.
            if (accept_rd || accept_wr || flag_err) begin
                armed_reg <= 1'b0;
            end else if (state_reg == ST_IDLE && strobes_idle) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;
    assign WAIT_L    = wait_l_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_re    = mem_re_reg;
    assign mem_we    = mem_we_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_z80_mem_responder.sv
// Bench for z80_mem_responder: three instances (WAIT_STATES 0, 2, 4) on one CPU bus,
// each with its own RAM, checked against timing rules and a reference memory image.
module tb_z80_mem_responder;

    localparam int N_DUT = 3;

    logic        clk = 1'b0;
    logic        rst_L, MREQ_L, RD_L, WR_L, RFSH_L;
    logic [15:0] addr;
    logic [7:0]  data_in;

    logic [7:0]  data_out  [N_DUT];
    logic        data_oe   [N_DUT];
    logic        wait_l    [N_DUT];
    logic [15:0] mem_addr  [N_DUT];
    logic [7:0]  mem_wdata [N_DUT];
    logic        mem_re    [N_DUT];
    logic        mem_we    [N_DUT];
    logic        bus_err   [N_DUT];
    logic [7:0]  mem_rdata [N_DUT];

    logic [7:0]  ram     [N_DUT][65536];
    logic [7:0]  ref_mem [65536];
    bit          ram_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
            z80_mem_responder #(.WAIT_STATES(2 * gi)) u_dut (
                .clk       (clk),
                .rst_L     (rst_L),
                .MREQ_L    (MREQ_L),
                .RD_L      (RD_L),
                .WR_L      (WR_L),
                .RFSH_L    (RFSH_L),
                .addr      (addr),
                .data_in   (data_in),
                .data_out  (data_out[gi]),
                .data_oe   (data_oe[gi]),
                .WAIT_L    (wait_l[gi]),
                .mem_addr  (mem_addr[gi]),
                .mem_wdata (mem_wdata[gi]),
                .mem_re    (mem_re[gi]),
                .mem_we    (mem_we[gi]),
                .mem_rdata (mem_rdata[gi]),
                .bus_err   (bus_err[gi])
            );
        end
    endgenerate

    function automatic logic [7:0] init_byte(input int a);
        logic [15:0] v;
        v = 16'(a);
        return (v[7:0] * 8'd37) ^ v[15:8] ^ 8'h5C;
    endfunction

    // Backing RAMs with registered read, preloaded on the first clock.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++)
                for (int d = 0; d < N_DUT; d++)
                    ram[d][i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else begin
            for (int d = 0; d < N_DUT; d++) begin
                if (mem_re[d]) mem_rdata[d] <= ram[d][mem_addr[d]];
                if (mem_we[d]) ram[d][mem_addr[d]] <= mem_wdata[d];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < N_DUT; d++) begin
            string t;
            t = $sformatf("%s ws%0d", tag, 2 * d);
            chk({t, " wait"},  wait_l[d],    1);
            chk({t, " oe"},    data_oe[d],   0);
            chk({t, " dout"},  data_out[d],  0);
            chk({t, " re"},    mem_re[d],    0);
            chk({t, " we"},    mem_we[d],    0);
            chk({t, " maddr"}, mem_addr[d],  0);
            chk({t, " wdata"}, mem_wdata[d], 0);
            chk({t, " err"},   bus_err[d],   0);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic exp_err);
        for (int d = 0; d < N_DUT; d++) begin
            string t;
            t = $sformatf("%s ws%0d", tag, 2 * d);
            chk({t, " wait"}, wait_l[d],  1);
            chk({t, " oe"},   data_oe[d], 0);
            chk({t, " re"},   mem_re[d],  0);
            chk({t, " we"},   mem_we[d],  0);
            chk({t, " err"},  bus_err[d], exp_err);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk_quiet("idle", 1'b0);
        end
    endtask

    // Strobes held through edge E0+hold, released before E0+hold+1.
    task automatic do_read(input logic [15:0] a, input int hold);
        @(negedge clk);
        addr = a; MREQ_L = 1'b0; RD_L = 1'b0;
        for (int k = 0; k <= hold + 2; k++) begin
            @(negedge clk);
            for (int d = 0; d < N_DUT; d++) begin
                int    ws, drv;
                bit    oe;
                string t;
                ws  = 2 * d;
                drv = (ws > 2) ? ws : 2;
                oe  = (k >= drv) && (k <= hold);
                t   = $sformatf("rd ws%0d a=%h k=%0d", ws, a, k);
                chk({t, " wait"}, wait_l[d],  !(k < ws && k <= hold));
                chk({t, " oe"},   data_oe[d], oe);
                chk({t, " re"},   mem_re[d],  k == 0);
                chk({t, " we"},   mem_we[d],  0);
                chk({t, " err"},  bus_err[d], 0);
                if (k <= hold) chk({t, " maddr"}, mem_addr[d], a);
                if (oe)        chk({t, " dout"},  data_out[d], ref_mem[a]);
            end
            if (k == hold) begin MREQ_L = 1'b1; RD_L = 1'b1; end
        end
        $display("[TB] read  addr=%h hold=%0d exp=%h", a, hold, ref_mem[a]);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] wd, input int hold);
        @(negedge clk);
        addr = a; data_in = wd; MREQ_L = 1'b0; WR_L = 1'b0;
        for (int k = 0; k <= hold + 2; k++) begin
            @(negedge clk);
            for (int d = 0; d < N_DUT; d++) begin
                int    ws;
                string t;
                ws = 2 * d;
                t  = $sformatf("wr ws%0d a=%h k=%0d", ws, a, k);
                chk({t, " wait"}, wait_l[d],  !(k < ws && k <= hold));
                chk({t, " oe"},   data_oe[d], 0);
                chk({t, " re"},   mem_re[d],  0);
                chk({t, " we"},   mem_we[d],  k == 0);
                chk({t, " err"},  bus_err[d], 0);
                if (k <= hold) begin
                    chk({t, " maddr"}, mem_addr[d],  a);
                    chk({t, " wdata"}, mem_wdata[d], wd);
                end
            end
            if (k == hold) begin MREQ_L = 1'b1; WR_L = 1'b1; end
        end
        ref_mem[a] = wd;
        for (int d = 0; d < N_DUT; d++)
            chk($sformatf("wr ws%0d a=%h ram", 2 * d, a), ram[d][a], wd);
        $display("[TB] write addr=%h data=%h hold=%0d", a, wd, hold);
    endtask

    // RD and WR both low for three cycles: a single error pulse, no RAM access.
    task automatic do_bus_err();
        @(negedge clk);
        MREQ_L = 1'b0; RD_L = 1'b0; WR_L = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk_quiet($sformatf("buserr k=%0d", k), k == 0);
            if (k == 2) begin MREQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; end
        end
        $display("[TB] bus_err cycle");
    endtask

    task automatic do_refresh(input logic rd);
        @(negedge clk);
        MREQ_L = 1'b0; RFSH_L = 1'b0; RD_L = rd;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk_quiet($sformatf("rfsh k=%0d", k), 1'b0);
            if (k == 2) begin MREQ_L = 1'b1; RFSH_L = 1'b1; RD_L = 1'b1; end
        end
        $display("[TB] refresh rd_l=%0b", rd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_L = 1'b0; MREQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; RFSH_L = 1'b1;
        addr = '0; data_in = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_L = 1'b1;
        idle_cycles(3);

        // Preload 0x1234 then read it back with a long hold.
        do_write(16'h1234, 8'hA5, 3);
        do_read(16'h1234, 5);
        do_write(16'h8000, 8'h5A, 0);
        do_read(16'h8000, 4);
        do_bus_err();
        idle_cycles(1);
        do_read(16'h2222, 1);
        do_refresh(1'b1);
        do_refresh(1'b0);

        // Reset in the middle of a read.
        @(negedge clk);
        addr = 16'h4321; MREQ_L = 1'b0; RD_L = 1'b0;
        repeat (3) @(negedge clk);
        rst_L = 1'b0;
        #1;
        chk_reset("rst mid");
        MREQ_L = 1'b1; RD_L = 1'b1;
        @(negedge clk);
        chk_reset("rst held");
        rst_L = 1'b1;
        idle_cycles(2);
        do_read(16'h0001, 5);

        for (int n = 0; n < 80; n++) begin
            int          sel, hold;
            logic [15:0] a;
            sel  = int'($urandom_range(0, 9));
            hold = int'($urandom_range(0, 6));
            a    = ($urandom_range(0, 1) == 0) ? {12'h0, 4'($urandom_range(0, 15))} : 16'($urandom);
            if (sel < 4)       do_read(a, hold);
            else if (sel < 8)  do_write(a, 8'($urandom), hold);
            else if (sel == 8) do_bus_err();
            else               do_refresh(1'($urandom_range(0, 1)));
        end
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_mem_responder.md
Z80_MEM_RESPONDER -- requirements
Module: z80_mem_responder

Interface
REQ-001 Param WAIT_STATES, default 1, number of cycles WAIT_L is held low per access (legal 0..15).
REQ-002 clk  input  1  single system clock, all state on posedge.
REQ-003 rst_L  input  1  reset, asynchronous, active-low.
REQ-004 MREQ_L  input  1  CPU memory request strobe, active-low.
REQ-005 RD_L  input  1  CPU read strobe, active-low.
REQ-006 WR_L  input  1  CPU write strobe, active-low.
REQ-007 RFSH_L  input  1  CPU refresh indicator, active-low.
REQ-008 addr  input  16  CPU address bus.
REQ-009 data_in  input  8  CPU write data.
REQ-010 data_out  output  8  read data to CPU, registered.
REQ-011 data_oe  output  1  data_out drive enable.
REQ-012 WAIT_L  output  1  wait request to CPU, active-low, registered.
REQ-013 mem_addr  output  16  backing-RAM address, registered.
REQ-014 mem_wdata  output  8  backing-RAM write data, registered.
REQ-015 mem_re / mem_we  output  1 each  one-cycle RAM read/write strobes.
REQ-016 mem_rdata  input  8  RAM read data, valid the cycle after mem_re.
REQ-017 bus_err  output  1  one-cycle pulse on illegal strobe combination.

Function
REQ-018 States SHALL be IDLE, RD_ISSUE, RD_WAIT, RD_DRIVE, WR_ISSUE, WR_WAIT, WR_HOLD.
REQ-019 IDLE: WAIT_L=1, data_oe=0, mem_re=0, mem_we=0.
REQ-020 Read detect: edge E0 sampling MREQ_L=0, RD_L=0, WR_L=1, RFSH_L=1 -> RD_ISSUE; mem_addr<=addr, mem_re<=1, wait counter<=WAIT_STATES.
REQ-021 Write detect: edge E0 sampling MREQ_L=0, WR_L=0, RD_L=1, RFSH_L=1 -> WR_ISSUE; mem_addr<=addr, mem_wdata<=data_in, mem_we<=1, counter<=WAIT_STATES.
REQ-022 mem_re/mem_we SHALL be high exactly one cycle (E0 to E0+1) per access.
REQ-023 WAIT_L SHALL be 0 from E0 to E0+WAIT_STATES (WAIT_STATES cycles), 1 otherwise; WAIT_STATES=0 -> never low.
REQ-024 Counter decrements by 1 per cycle while nonzero; never wraps below 0.
REQ-025 Read: data_out<=mem_rdata captured at E0+2; data_oe=1 from edge E0+max(2,WAIT_STATES) -> RD_DRIVE.
REQ-026 RD_DRIVE: data_out, data_oe held while MREQ_L=0 and RD_L=0; either high -> IDLE, data_oe=0 next cycle.
REQ-027 Write: WR_WAIT until counter=0, then WR_HOLD until MREQ_L or WR_L high -> IDLE.
REQ-028 MREQ_L=0 with RD_L=0 and WR_L=0 in IDLE: stay IDLE, bus_err pulse, no RAM strobe.
REQ-029 MREQ_L=0 with RFSH_L=0: ignored, no RAM strobe, no bus_err.
REQ-030 Abort: MREQ_L or active strobe high before RD_DRIVE/WR_HOLD -> IDLE next edge, WAIT_L=1, data_oe=0; issued write stays committed, read data discarded.
REQ-031 A new access SHALL NOT be accepted until one cycle in IDLE with strobes sampled high (no back-to-back re-trigger on held strobes).

Reset
REQ-032 rst_L=0 SHALL asynchronously force IDLE, WAIT_L=1, data_oe=0, data_out=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0, counter=0, including mid-access.

Structure
REQ-033 State enum (mem_resp_state_t) and wait-counter width constant SHALL live in shared package z80_pkg.
REQ-034 Wait-state countdown SHALL be sub-module z80_wait_ctr (load, decrement, zero flag).

Verification
REQ-035 WAIT_STATES=2, RAM[0x1234]=0xA5, read 0x1234 -> mem_re one cycle, WAIT_L low 2 cycles, data_oe=1/data_out=0xA5 from E0+2, data_oe=0 one cycle after RD_L rises.
REQ-036 WAIT_STATES=0, write 0x5A to 0x8000 -> mem_we one cycle with mem_addr=0x8000, mem_wdata=0x5A, WAIT_L never low.
REQ-037 RD_L=0 and WR_L=0 with MREQ_L=0 -> bus_err one-cycle pulse, no mem_re/mem_we, stays IDLE.
REQ-038 WAIT_STATES=4, RD_L released at E0+1 -> IDLE at E0+2, WAIT_L=1, data_oe never asserted.
REQ-039 rst_L low mid-RD_WAIT -> immediately WAIT_L=1, data_oe=0; after release, next read of 0x0001 completes normally.
REQ-040 MREQ_L=0, RFSH_L=0 for 3 cycles -> no RAM strobe, WAIT_L=1, bus_err=0.
